// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-16 demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CH_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/demux_chreg.sv
// One demux channel: data register with load, synchronous clear and async reset.
module demux_chreg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/demux_1to16.sv
// 1-to-16 registered demultiplexer with auto-increment pointer and sequential clear.
// Optional macro DEMUX_WRITTEN_FLAGS_EN adds per-channel written flags and all_written.
module demux_1to16
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic [DATA_W-1:0] in,
    input  logic [CH_W-1:0]   sel,
    input  logic              wr_en,
    input  logic              auto,
    input  logic              clr,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic [DATA_W-1:0] outC,
    output logic [DATA_W-1:0] outD,
    output logic [DATA_W-1:0] outE,
    output logic [DATA_W-1:0] outF,
    output logic [DATA_W-1:0] outG,
    output logic [DATA_W-1:0] outH,
    output logic [DATA_W-1:0] outI,
    output logic [DATA_W-1:0] outJ,
    output logic [DATA_W-1:0] outK,
    output logic [DATA_W-1:0] outL,
    output logic [DATA_W-1:0] outM,
    output logic [DATA_W-1:0] outN,
    output logic [DATA_W-1:0] outO,
    output logic [DATA_W-1:0] outP,
    output logic              ready,
    output logic [CH_W-1:0]   ptr,
    output logic              frame_done
`ifdef DEMUX_WRITTEN_FLAGS_EN
    ,
    output logic [NUM_CH-1:0] written,
    output logic              all_written
`endif
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   clr_idx_q, clr_idx_d;
    logic              frame_done_q, frame_done_d;
    logic              wr_acc;
    logic [CH_W-1:0]   dest;
    logic [NUM_CH-1:0] ch_load;
    logic [NUM_CH-1:0] ch_clr;
    logic [DATA_W-1:0] ch_q [NUM_CH];

    // clr wins over a simultaneous write, so a write is only accepted when clr is low
    assign wr_acc = (state_q == IDLE) && wr_en && !clr;
    assign dest   = auto ? ptr_q : sel;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_idx_d    = clr_idx_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (wr_en && auto) begin
                    ptr_d        = ptr_q + CH_W'(1);
                    frame_done_d = (ptr_q == CH_W'(NUM_CH - 1));
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + CH_W'(1);
                if (clr_idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            clr_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_idx_q    <= clr_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign ch_load[n] = wr_acc && (dest == CH_W'(n));
        assign ch_clr[n]  = (state_q == CLEAR) && (clr_idx_q == CH_W'(n));

        demux_chreg #(
            .WIDTH(DATA_W)
        ) u_chreg (
            .clk    (clk),
            .rst    (res),
            .load_i (ch_load[n]),
            .clr_i  (ch_clr[n]),
            .d_i    (in),
            .q_o    (ch_q[n])
        );
    end

`ifdef DEMUX_WRITTEN_FLAGS_EN
    logic [NUM_CH-1:0] written_q, written_d;

    always_comb begin
        written_d = written_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_clr[i]) begin
                written_d[i] = 1'b0;
            end else if (ch_load[i]) begin
                written_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    assign written     = written_q;
    assign all_written = &written_q;
`endif

    assign ready      = (state_q == IDLE);
    assign ptr        = ptr_q;
    assign frame_done = frame_done_q;

    assign outA = ch_q[0];
    assign outB = ch_q[1];
    assign outC = ch_q[2];
    assign outD = ch_q[3];
    assign outE = ch_q[4];
    assign outF = ch_q[5];
    assign outG = ch_q[6];
    assign outH = ch_q[7];
    assign outI = ch_q[8];
    assign outJ = ch_q[9];
    assign outK = ch_q[10];
    assign outL = ch_q[11];
    assign outM = ch_q[12];
    assign outN = ch_q[13];
    assign outO = ch_q[14];
    assign outP = ch_q[15];

endmodule
